i2c_tx_burst_sequencer: RTL

- Sits directly downstream of the transmitter control register.
- Consumes the programmed transfer size (bytes per burst) and burst count (bursts per transaction).
- Pulls payload bytes from a byte source over a valid/ready handshake and feeds the I2C byte shifter one byte at a time.
- Frames each burst with START/STOP requests, inserts a fixed idle gap between bursts, and reports progress and completion.

---
 rtl/i2c_tx_burst_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/i2c_tx_burst_sequencer.sv
// Burst sequencer between the TX control register and the I2C byte shifter.
// Frames bursts with START/STOP, pulls payload bytes, spaces bursts by a gap.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, tsize,       transaction request; size/burst latched on accept
//   tburst
//   src_data/valid/     payload byte source (valid/ready)
//   ready
//   tx_data, tx_load,   byte and one-cycle command pulses to the shifter
//   tx_start, tx_stop
//   tx_done             shifter completion pulse for START/byte/STOP
//   busy, done          transaction status; done is a one-cycle pulse
//   byte_cnt, burst_cnt progress counters
module i2c_tx_burst_sequencer #(
  parameter int DW         = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] tsize,
  input  logic [DW-1:0] tburst,
  input  logic [DW-1:0] src_data,
  input  logic          src_valid,
  output logic          src_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_load,
  output logic          tx_start,
  output logic          tx_stop,
  input  logic          tx_done,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] byte_cnt,
  output logic [DW-1:0] burst_cnt
);

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    SBIT,
    SWAIT,
    FETCH,
    LOAD,
    BWAIT,
    PBIT,
    PWAIT,
    GAP,
    FIN
  } state_t;

  state_t        state;
  logic [DW-1:0] size_q;
  logic [DW-1:0] burst_q;
  logic [7:0]    gap_cnt;
  logic [DW-1:0] byte_nx;
  logic [DW-1:0] burst_nx;

  assign byte_nx  = byte_cnt + DW'(1);
  assign burst_nx = burst_cnt + DW'(1);

  // Outputs are registered: each is set on the transition into the
  // state that owns it, so it is high for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      size_q    <= '0;
      burst_q   <= '0;
      gap_cnt   <= '0;
      src_ready <= 1'b0;
      tx_data   <= '0;
      tx_load   <= 1'b0;
      tx_start  <= 1'b0;
      tx_stop   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      tx_load  <= 1'b0;
      tx_start <= 1'b0;
      tx_stop  <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            size_q    <= tsize;
            burst_q   <= tburst;
            byte_cnt  <= '0;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (size_q == '0 || burst_q == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            tx_start <= 1'b1;
            state    <= SBIT;
          end
        end
        SBIT: state <= SWAIT;
        SWAIT: begin
          if (tx_done) begin
            src_ready <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (src_valid) begin
            tx_data   <= src_data;
            src_ready <= 1'b0;
            tx_load   <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: state <= BWAIT;
        BWAIT: begin
          if (tx_done) begin
            byte_cnt <= byte_nx;
            if (byte_nx == size_q) begin
              tx_stop <= 1'b1;
              state   <= PBIT;
            end else begin
              src_ready <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        PBIT: state <= PWAIT;
        PWAIT: begin
          if (tx_done) begin
            burst_cnt <= burst_nx;
            if (burst_nx == burst_q) begin
              // final counts stay visible until the next start
              done  <= 1'b1;
              state <= FIN;
            end else begin
              byte_cnt <= '0;
              gap_cnt  <= 8'(GAP_CYCLES - 1);
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            tx_start <= 1'b1;
            state    <= SBIT;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
